// File: rtl/multi_seq.sv
// Limb-serial wide-integer multiplier: one LIMB_WIDTH x LIMB_WIDTH partial product
// is accumulated per cycle. A final cycle applies the two's complement correction.
module multi_seq #(
  parameter int DATA_WIDTH = 1024,
  parameter int LIMB_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   dat1,
  input  logic [DATA_WIDTH-1:0]   dat2,
  input  logic                    is_signed,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic                    busy
);

  localparam int NLIMB = DATA_WIDTH / LIMB_WIDTH;
  localparam int NPP   = NLIMB * NLIMB;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  typedef enum logic [1:0] {IDLE, MUL, FIX, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                  sgn_q, sgn_d;
  logic [PW-1:0]         acc_q, acc_d;
  logic [PW-1:0]         product_q, product_d;
  logic                  out_valid_q, out_valid_d;
  logic [CW-1:0]         i_q, i_d, j_q, j_d;

  logic [LIMB_WIDTH-1:0]   a_limb, b_limb;
  logic [2*LIMB_WIDTH-1:0] pp;
  logic [PW-1:0]           pp_shifted;
  logic [PW-1:0]           fix_val;
  logic                    last_pp;

  // Datapath: current partial product and the signed correction of the unsigned sum.
  always_comb begin
    a_limb     = a_q[int'(i_q)*LIMB_WIDTH +: LIMB_WIDTH];
    b_limb     = b_q[int'(j_q)*LIMB_WIDTH +: LIMB_WIDTH];
    pp         = {{LIMB_WIDTH{1'b0}}, a_limb} * {{LIMB_WIDTH{1'b0}}, b_limb};
    pp_shifted = PW'(pp) << (LIMB_WIDTH * (int'(i_q) + int'(j_q)));
    last_pp    = (int'(i_q) * NLIMB + int'(j_q)) == (NPP - 1);
    fix_val    = acc_q;
    if (sgn_q && a_q[DATA_WIDTH-1]) fix_val = fix_val - {b_q, {DATA_WIDTH{1'b0}}};
    if (sgn_q && b_q[DATA_WIDTH-1]) fix_val = fix_val - {a_q, {DATA_WIDTH{1'b0}}};
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sgn_d       = sgn_q;
    acc_d       = acc_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    i_d         = i_q;
    j_d         = j_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = dat1;
          b_d     = dat2;
          sgn_d   = is_signed;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = acc_q + pp_shifted;
        if (j_q == CW'(NLIMB - 1)) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
        if (last_pp) begin
          i_d     = '0;
          state_d = FIX;
        end
      end
      FIX: begin
        product_d   = fix_val;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      acc_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      i_q         <= '0;
      j_q         <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sgn_q       <= sgn_d;
      acc_q       <= acc_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
      i_q         <= i_d;
      j_q         <= j_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_multi_seq.sv
// Checks a 16/8 instance with directed cases and a 1024/64 instance with random
// operands against a plain-arithmetic reference product.
module tb_multi_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        s_in_valid, s_in_ready, s_is_signed, s_out_valid, s_out_ready, s_busy;
  logic [15:0] s_dat1, s_dat2;
  logic [31:0] s_product;

  logic          b_in_valid, b_in_ready, b_is_signed, b_out_valid, b_out_ready, b_busy;
  logic [1023:0] b_dat1, b_dat2;
  logic [2047:0] b_product;

  int vectors = 0;
  int miscompares = 0;

  multi_seq #(.DATA_WIDTH(16), .LIMB_WIDTH(8)) u_small (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .dat1(s_dat1), .dat2(s_dat2), .is_signed(s_is_signed),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .product(s_product), .busy(s_busy)
  );

  multi_seq u_big (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .dat1(b_dat1), .dat2(b_dat2), .is_signed(b_is_signed),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .product(b_product), .busy(b_busy)
  );

  // Reference: sign- or zero-extend both operands, multiply, keep 2*dw bits.
  function automatic logic [2047:0] ref_mul(input logic [1023:0] a, input logic [1023:0] b,
                                            input logic sg, input int dw);
    logic [2047:0] ae, be, ext, mask;
    ext = ~((2048'd1 << dw) - 2048'd1);
    ae  = {1024'd0, a};
    be  = {1024'd0, b};
    if (sg && a[dw-1]) ae = ae | ext;
    if (sg && b[dw-1]) be = be | ext;
    mask = (2 * dw >= 2048) ? {2048{1'b1}} : ((2048'd1 << (2 * dw)) - 2048'd1);
    return (ae * be) & mask;
  endfunction

  task automatic chk(input string tag, input logic [2047:0] obs, input logic [2047:0] exp);
    int diff_bit;
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      diff_bit = -1;
      for (int k = 2047; k >= 0; k--) if (obs[k] !== exp[k]) diff_bit = k;
      $error("FAIL %s: observed[127:0]=%0h required[127:0]=%0h first_diff_bit=%0d",
             tag, obs[127:0], exp[127:0], diff_bit);
    end
  endtask

  task automatic run_small(input logic [15:0] d1, input logic [15:0] d2, input logic sg,
                           input logic [31:0] exp_p, input string tag);
    int n;
    logic rdy_seen;
    chk({tag, "/in_ready_before"}, s_in_ready, 1);
    s_dat1 = d1; s_dat2 = d2; s_is_signed = sg; s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    n = 0; rdy_seen = 1'b0;
    while (!s_out_valid && n < 20) begin
      if (s_in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    chk({tag, "/latency"}, n, 5);
    chk({tag, "/in_ready_during"}, rdy_seen, 0);
    chk({tag, "/product"}, s_product, exp_p);
    $display("small %s: dat1=%h dat2=%h signed=%0d product=%h edges=%0d", tag, d1, d2, sg, s_product, n);
    if (s_out_ready) begin
      @(negedge clk);
      chk({tag, "/out_valid_after"}, s_out_valid, 0);
      chk({tag, "/in_ready_after"}, s_in_ready, 1);
    end
  endtask

  task automatic run_big(input logic [1023:0] d1, input logic [1023:0] d2, input logic sg, input int idx);
    int n, hold;
    logic [2047:0] exp_p;
    exp_p = ref_mul(d1, d2, sg, 1024);
    b_out_ready = 1'b0;
    chk($sformatf("big%0d/in_ready_before", idx), b_in_ready, 1);
    b_dat1 = d1; b_dat2 = d2; b_is_signed = sg; b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("big%0d/latency", idx), n, 257);
    chk($sformatf("big%0d/product", idx), b_product, exp_p);
    hold = $urandom_range(0, 3);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk($sformatf("big%0d/hold_product", idx), b_product, exp_p);
    end
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    chk($sformatf("big%0d/out_valid_after", idx), b_out_valid, 0);
    chk($sformatf("big%0d/in_ready_after", idx), b_in_ready, 1);
    $display("big op %0d: signed=%0d product[63:0]=%h edges=%0d hold=%0d", idx, sg, b_product[63:0], n, hold);
  endtask

  initial begin
    logic [31:0]   held;
    logic [1023:0] r1, r2;
    rst = 1'b1;
    s_in_valid = 1'b0; s_dat1 = '0; s_dat2 = '0; s_is_signed = 1'b0; s_out_ready = 1'b1;
    b_in_valid = 1'b0; b_dat1 = '0; b_dat2 = '0; b_is_signed = 1'b0; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("reset/in_ready", s_in_ready, 1);
    chk("reset/busy", s_busy, 0);
    chk("reset/out_valid", s_out_valid, 0);
    chk("reset/product", s_product, 0);
    chk("reset/big_in_ready", b_in_ready, 1);
    chk("reset/big_busy", b_busy, 0);

    run_small(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "unsigned_max");
    run_small(16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE, "mode_signed");
    run_small(16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE, "mode_unsigned");
    run_small(16'h8000, 16'h8000, 1'b1, 32'h40000000, "signed_min_min");
    run_small(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, "signed_min_max");
    run_small(16'h0000, 16'hABCD, 1'b1, 32'h00000000, "zero_operand");

    // Backpressure: result held while the consumer stalls; new requests ignored.
    s_out_ready = 1'b0;
    run_small(16'h1234, 16'h0003, 1'b0, 32'h0000369C, "backpressure");
    held = s_product;
    for (int k = 0; k < 10; k++) begin
      s_in_valid = k[0]; s_dat1 = 16'hDEAD; s_dat2 = 16'hBEEF;
      @(negedge clk);
      chk("bp/out_valid", s_out_valid, 1);
      chk("bp/product", s_product, held);
      chk("bp/in_ready", s_in_ready, 0);
    end
    s_in_valid = 1'b0;
    s_out_ready = 1'b1;
    @(negedge clk);
    chk("bp/out_valid_released", s_out_valid, 0);
    chk("bp/in_ready_released", s_in_ready, 1);
    chk("bp/product_retained", s_product, 32'h0000369C);
    run_small(16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF, "after_bp");

    // Reset in the second MUL cycle aborts the operation.
    s_dat1 = 16'hFFFF; s_dat2 = 16'hFFFF; s_is_signed = 1'b0; s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    chk("rst_mid/busy_in_mul", s_busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid/out_valid", s_out_valid, 0);
    chk("rst_mid/product", s_product, 0);
    chk("rst_mid/busy", s_busy, 0);
    chk("rst_mid/in_ready", s_in_ready, 1);
    run_small(16'h1234, 16'h5678, 1'b0, 32'h06260060, "after_reset");

    // Random 1024-bit operations, including all-zero and all-ones operands.
    for (int idx = 0; idx < 100; idx++) begin
      for (int w = 0; w < 32; w++) begin
        r1[w*32 +: 32] = $urandom();
        r2[w*32 +: 32] = $urandom();
      end
      if (idx == 0) r1 = '0;
      if (idx == 1) begin r1 = '1; r2 = '1; end
      run_big(r1, r2, 1'($urandom_range(0, 1)), idx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
